// File: rtl/imem_loadable_pkg.sv
// imem_loadable shared types: FSM state, NOP word and pc-to-index helper.
package imem_pkg;

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        LOAD
    } imem_state_t;

    localparam int NOP_WORD = 0;

    // Word index from a byte address; caller truncates to its index width.
    function automatic logic [63:0] imem_idx(
        input logic [63:0] pc,
        input int          idx_w
    );
        return (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
    endfunction

endpackage

// File: rtl/imem_loadable_if.sv
// Load-port bundle for imem_loadable: start/base plus a valid/ready word stream.
interface imem_loadable_if #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 6
);
    logic              ld_start;
    logic [IDX_W-1:0]  ld_base;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;
    logic              ld_ready;
    logic              ld_done;

    modport master (
        output ld_start, ld_base, ld_valid, ld_data, ld_last,
        input  ld_ready, ld_done
    );

    modport slave (
        input  ld_start, ld_base, ld_valid, ld_data, ld_last,
        output ld_ready, ld_done
    );
endinterface

// File: rtl/imem_loadable_store.sv
// imem_store: DEPTH x DATA_W array, one synchronous write port, one async read port.
module imem_store #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int IDX_W  = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) r_mem[waddr] <= wdata;
    end

    assign rdata = r_mem[raddr];
endmodule

// File: rtl/imem_loadable.sv
// Loadable instruction memory: post-reset clear sweep, streamed load, comb fetch.
// Optional IMEM_FAULT_EN adds a fault output for misaligned/out-of-range pc.
module imem_loadable
    import imem_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 64,
    parameter  int PC_W   = 32,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PC_W-1:0]   pc,
    output logic [DATA_W-1:0] instruction,
    output logic              imem_ready,
`ifdef IMEM_FAULT_EN
    output logic              fault,
`endif
    imem_loadable_if.slave    ld
);
    imem_state_t       r_state;
    imem_state_t       w_next;
    logic [IDX_W-1:0]  r_clr_idx;
    logic [IDX_W-1:0]  r_wptr;
    logic              r_done;
    logic              w_acc;
    logic              w_we;
    logic              w_fault;
    logic [IDX_W-1:0]  w_waddr;
    logic [IDX_W-1:0]  w_raddr;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_rdata;

    assign w_acc   = (r_state == LOAD) && ld.ld_valid;
    assign w_raddr = IDX_W'(imem_idx(64'(pc), IDX_W));

`ifdef IMEM_FAULT_EN
    assign w_fault = (r_state == IDLE) &&
                     ((pc[1:0] != 2'b00) || ((pc >> (IDX_W + 2)) != '0));
    assign fault   = w_fault;
`else
    assign w_fault = 1'b0;
`endif

    assign imem_ready  = (r_state == IDLE);
    assign ld.ld_ready = (r_state == LOAD);
    assign ld.ld_done  = r_done;
    assign instruction = (r_state == IDLE && !w_fault) ?
                         w_rdata : DATA_W'(NOP_WORD);

    // Clear sweep and loader share the single write port.
    always_comb begin
        w_next  = r_state;
        w_we    = 1'b0;
        w_waddr = r_clr_idx;
        w_wdata = DATA_W'(NOP_WORD);
        unique case (r_state)
            CLEAR: begin
                w_we = 1'b1;
                if (r_clr_idx == IDX_W'(DEPTH - 1)) w_next = IDLE;
            end
            IDLE: begin
                if (ld.ld_start) w_next = LOAD;
            end
            LOAD: begin
                w_we    = w_acc;
                w_waddr = r_wptr;
                w_wdata = ld.ld_data;
                if (w_acc && ld.ld_last) w_next = IDLE;
            end
            default: w_next = CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= CLEAR;
            r_clr_idx <= '0;
            r_wptr    <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= w_acc && ld.ld_last;
            if (r_state == CLEAR) r_clr_idx <= r_clr_idx + 1'b1;
            if (r_state == IDLE && ld.ld_start) r_wptr <= ld.ld_base;
            else if (w_acc) r_wptr <= r_wptr + 1'b1;
        end
    end

    imem_store #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_store (
        .clk  (clk),
        .we   (w_we),
        .waddr(w_waddr),
        .wdata(w_wdata),
        .raddr(w_raddr),
        .rdata(w_rdata)
    );
endmodule

// File: tb/tb_imem_loadable.sv
// Directed bench for imem_loadable: clear sweep, loads, gaps, wrap, reset abort.
module tb_imem_loadable;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        imem_ready;
`ifdef IMEM_FAULT_EN
    logic        fault;
`endif
    int tests = 0;
    int fails = 0;
    int done_cnt = 0;

    imem_loadable_if #(.DATA_W(32), .IDX_W(6)) ld_if ();

    imem_loadable #(.DATA_W(32), .DEPTH(64), .PC_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc         (pc),
        .instruction(instruction),
        .imem_ready (imem_ready),
`ifdef IMEM_FAULT_EN
        .fault      (fault),
`endif
        .ld         (ld_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ld_if.ld_done === 1'b1) done_cnt++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s got %h exp %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp,
                      input string tag);
        pc = a;
        #1;
        check(tag, instruction, exp);
    endtask

    task automatic start(input logic [5:0] base);
        ld_if.ld_start = 1'b1;
        ld_if.ld_base  = base;
        tick;
        ld_if.ld_start = 1'b0;
    endtask

    task automatic beat(input logic [31:0] d, input logic v, input logic l);
        ld_if.ld_valid = v;
        ld_if.ld_data  = d;
        ld_if.ld_last  = l;
        tick;
        ld_if.ld_valid = 1'b0;
        ld_if.ld_last  = 1'b0;
    endtask

    task automatic sweep(input string tag);
        for (int i = 1; i <= 64; i++) begin
            tick;
            check(tag, 32'(imem_ready), 32'(i == 64));
        end
    endtask

    initial begin
        rst = 1'b0;
        pc  = '0;
        ld_if.ld_start = 1'b0;
        ld_if.ld_base  = '0;
        ld_if.ld_valid = 1'b0;
        ld_if.ld_data  = '0;
        ld_if.ld_last  = 1'b0;
        repeat (3) tick;
        check("rst_ready", 32'(imem_ready), 32'd0);
        check("rst_ldready", 32'(ld_if.ld_ready), 32'd0);
        check("rst_done", 32'(ld_if.ld_done), 32'd0);
        check("rst_instr", instruction, 32'd0);
`ifdef IMEM_FAULT_EN
        check("rst_fault", 32'(fault), 32'd0);
`endif
        rst = 1'b1;
        sweep("clear_ready");
        for (int a = 0; a < 256; a += 4) rd(32'(a), 32'd0, "clear_rd");

        // Basic three-word load at base 0.
        start(6'd0);
        check("ld_ldready", 32'(ld_if.ld_ready), 32'd1);
        check("ld_ready_lo", 32'(imem_ready), 32'd0);
        check("ld_nop", instruction, 32'd0);
        beat(32'h20100015, 1'b1, 1'b0);
        beat(32'h20110017, 1'b1, 1'b0);
        check("ld_done_early", 32'(ld_if.ld_done), 32'd0);
        beat(32'hAE300004, 1'b1, 1'b1);
        check("ld_done_hi", 32'(ld_if.ld_done), 32'd1);
        check("ld_ready_back", 32'(imem_ready), 32'd1);
        tick;
        check("ld_done_lo", 32'(ld_if.ld_done), 32'd0);
        check("ld_done_cnt", 32'(done_cnt), 32'd1);
        rd(32'd0, 32'h20100015, "ld_rd0");
        rd(32'd4, 32'h20110017, "ld_rd1");
        rd(32'd8, 32'hAE300004, "ld_rd2");

        // Same words with gaps; a stray ld_last without ld_valid is ignored.
        start(6'd0);
        beat(32'h20100015, 1'b1, 1'b0);
        beat(32'hDEADBEEF, 1'b0, 1'b1);
        check("gap_still_load", 32'(ld_if.ld_ready), 32'd1);
        beat(32'h20110017, 1'b1, 1'b0);
        beat(32'hCAFEF00D, 1'b0, 1'b0);
        check("gap_done_early", 32'(ld_if.ld_done), 32'd0);
        beat(32'hAE300004, 1'b1, 1'b1);
        check("gap_done_hi", 32'(ld_if.ld_done), 32'd1);
        tick;
        check("gap_done_cnt", 32'(done_cnt), 32'd2);
        rd(32'd0, 32'h20100015, "gap_rd0");
        rd(32'd4, 32'h20110017, "gap_rd1");
        rd(32'd8, 32'hAE300004, "gap_rd2");
        rd(32'd12, 32'd0, "gap_rd3");

        // Seed index 5, then a wrapping session from base 62.
        start(6'd5);
        beat(32'h55555555, 1'b1, 1'b1);
        tick;
        start(6'd62);
        beat(32'h11111111, 1'b1, 1'b0);
        ld_if.ld_start = 1'b1;
        ld_if.ld_base  = 6'd10;
        beat(32'h22222222, 1'b1, 1'b0);
        ld_if.ld_start = 1'b0;
        beat(32'h33333333, 1'b1, 1'b0);
        beat(32'h44444444, 1'b1, 1'b1);
        tick;
        check("wrap_done_cnt", 32'(done_cnt), 32'd4);
        rd(32'd248, 32'h11111111, "wrap_rd62");
        rd(32'd252, 32'h22222222, "wrap_rd63");
        rd(32'd0, 32'h33333333, "wrap_rd0");
        rd(32'd4, 32'h44444444, "wrap_rd1");
        rd(32'd8, 32'hAE300004, "wrap_rd2");
        rd(32'd20, 32'h55555555, "wrap_rd5");
        rd(32'd40, 32'd0, "wrap_rd10");

`ifdef IMEM_FAULT_EN
        rd(32'h2, 32'd0, "flt_mis_instr");
        check("flt_mis", 32'(fault), 32'd1);
        rd(32'h100, 32'd0, "flt_oor_instr");
        check("flt_oor", 32'(fault), 32'd1);
        rd(32'hFC, 32'h22222222, "flt_ok_instr");
        check("flt_ok", 32'(fault), 32'd0);
`else
        rd(32'h100, 32'h33333333, "alias_100");
        rd(32'h102, 32'h33333333, "alias_mis");
        rd(32'hFE, 32'h22222222, "alias_fe");
`endif

        // Reset after two of four words: session aborts, sweep reruns.
        start(6'd0);
        beat(32'h99990001, 1'b1, 1'b0);
        beat(32'h99990002, 1'b1, 1'b0);
        ld_if.ld_valid = 1'b1;
        ld_if.ld_data  = 32'h99990003;
        rst = 1'b0;
        #1;
        check("mid_ldready", 32'(ld_if.ld_ready), 32'd0);
        check("mid_ready", 32'(imem_ready), 32'd0);
        check("mid_instr", instruction, 32'd0);
        check("mid_done", 32'(ld_if.ld_done), 32'd0);
        ld_if.ld_valid = 1'b0;
        repeat (2) tick;
        rst = 1'b1;
        sweep("mid_sweep");
        for (int a = 0; a < 256; a += 4) rd(32'(a), 32'd0, "mid_rd");
        check("mid_done_cnt", 32'(done_cnt), 32'd4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/imem_loadable.md
Name: imem_loadable

Overview:
Parametrised instruction memory for the single-cycle CPU, succeeding the fixed 64-word ROM.
- Depth and word width are parametrised. Contents are cleared by a hardware sweep after reset, not set by a reset-edge initialiser.
- Programs are streamed in through a valid/ready load port.
- Fetch stays combinational, so the CPU keeps single-cycle timing.

Parameters:
DATA_W, 32, instruction word width
DEPTH, 64, number of words; power of two, at least 4
PC_W, 32, program-counter width
IDX_W, $clog2(DEPTH), word-index width (derived; not overridden)

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst  in  1  reset, asynchronous, active-low
pc  in  PC_W  byte address from the CPU
instruction  out  DATA_W  fetched word (combinational)
imem_ready  out  1  high when the memory holds a valid program and fetch is live
ld_start  in  1  single-cycle pulse that opens a load session
ld_base  in  IDX_W  first word index of the session, sampled with ld_start
ld_valid  in  1  ld_data is valid this cycle
ld_data  in  DATA_W  word to write
ld_last  in  1  marks the final word of the session
ld_ready  out  1  block accepts a word this cycle
ld_done  out  1  one-cycle pulse after the last word is written

Behaviour:
- States: CLEAR, IDLE, LOAD.
- While rst is low: state=CLEAR, clr_idx=0, wptr=0, imem_ready=0, ld_ready=0, ld_done=0, instruction=0.
- The array itself has no asynchronous reset.
- CLEAR:
  - Writes 0 to word clr_idx each cycle and increments clr_idx.
  - After writing index DEPTH-1, moves to IDLE. That is exactly DEPTH cycles after rst rises.
  - imem_ready rises on the first IDLE cycle.
  - ld_start is ignored (not queued).
- IDLE:
  - instruction = mem[pc[IDX_W+1:2]] combinationally. Zero-cycle latency.
  - pc bits above IDX_W+1 are ignored (address aliases) unless IMEM_FAULT_EN is defined.
  - ld_start=1 → LOAD on the next edge, with wptr<=ld_base.
- LOAD:
  - imem_ready=0, ld_ready=1, instruction forced to 0 (NOP). There is no read-during-write hazard.
  - On ld_valid&ld_ready: mem[wptr]<=ld_data and wptr<=wptr+1, wrapping from DEPTH-1 to 0.
  - Gaps in ld_valid are allowed; nothing is written on those cycles.
  - An accepted beat with ld_last=1 is written, then → IDLE. ld_done=1 for exactly that next cycle, coincident with imem_ready rising.
  - ld_last without ld_valid has no effect.
  - ld_start during LOAD is ignored.
  - Words not written in a session keep their previous contents.
  - A session longer than DEPTH wraps and overwrites earlier words of the same session. This is permitted, not flagged.
- Reset mid-operation (rst low in any state): the session is aborted at once and the full CLEAR sweep reruns.

Optional Feature:
Macro IMEM_FAULT_EN.
- Defined:
  - Adds output port fault (1 bit), which is 0 during reset, CLEAR and LOAD.
  - In IDLE, fault = (pc[1:0]!=0) or (pc[PC_W-1:IDX_W+2]!=0), combinational.
  - When fault=1, instruction is forced to 0.
- Undefined:
  - No fault port.
  - Misaligned pc truncates the low two bits.
  - Out-of-range pc aliases modulo DEPTH.

Decomposition:
- Package imem_pkg holds:
  - the state enum imem_state_t {CLEAR, IDLE, LOAD};
  - localparam NOP_WORD = 0;
  - a function imem_idx(pc) that extracts the word index.
- One sub-module is natural: imem_store. It holds the DEPTH×DATA_W array, one synchronous write port (we, waddr, wdata) and one combinational read port.
- The CLEAR sweep and the LOAD writer share the store's single write port through a state-selected mux.

Test Plan:
- Reset release (DEPTH=64): rst low 3 cycles, then high → imem_ready=0 for 64 cycles, 1 on cycle 65. pc=0..252 step 4 all read 0.
- Basic load: ld_start with ld_base=0, then words 0x20100015, 0x20110017, 0xAE300004 (last) → ld_done pulses once. Reads are pc=0→0x20100015, pc=4→0x20110017, pc=8→0xAE300004.
- Backpressure gaps: same 3 words with ld_valid low on alternating cycles → identical contents. ld_done is delayed accordingly, and no extra writes occur.
- Wrap-around: ld_base=62, words A,B,C,D (D last) → pc=248→A, 252→B, 0→C, 4→D. Index 5 keeps its prior value.
- Reset mid-load: assert rst after 2 of 4 words are accepted → after the 64-cycle CLEAR, all words read 0 and ld_done never pulses.
- IMEM_FAULT_EN defined:
  - pc=0x2 → fault=1, instruction=0.
  - pc=0x100 → fault=1, instruction=0.
  - pc=0xFC → fault=0 and the stored word is returned.
  - Undefined: pc=0x100 returns the word at index 0.
